// File: rtl/pool_flatten_stream.sv
// Captures a pooled multi-channel frame in one cycle and streams it out word by word (channel-major) over valid/ready.
// Optional ReLU on the read path is enabled by defining POOL_FLATTEN_RELU_EN.
module pool_flatten_stream #(
   parameter  int Felements = 3,
   parameter  int Elements  = 5,
   localparam int N         = Felements * Elements * Elements,
   localparam int IDX_W     = $clog2(N)
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic [Felements-1:0][Elements-1:0][Elements-1:0][31:0] ImagesIn,
   input  logic                                                 in_valid,
   output logic [31:0]                                          out_data,
   output logic                                                 out_valid,
   input  logic                                                 out_ready,
   output logic [IDX_W-1:0]                                     out_index,
   output logic                                                 out_last,
   output logic                                                 busy,
   output logic                                                 done,
   output logic                                                 overflow
);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] index;
   logic [IDX_W-1:0] index_next;
   logic [31:0]      frame_buf [N];
   logic             capture;
   logic             done_next;
   logic             overflow_set;
   logic             xfer;
   logic             at_last;

   function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef POOL_FLATTEN_RELU_EN
      // Sign bit set covers every negative value and -0.0; all become +0.0.
      return x[31] ? 32'h0000_0000 : x;
`else
      return x;
`endif
   endfunction

   assign xfer    = (state == STREAM) && out_ready;
   assign at_last = (index == IDX_W'(N - 1));

   always_comb begin
      state_next   = state;
      index_next   = index;
      capture      = 1'b0;
      done_next    = 1'b0;
      overflow_set = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               capture    = 1'b1;
               index_next = '0;
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (xfer && at_last) begin
               // A new frame arriving on the final beat chains straight into the next stream.
               done_next  = 1'b1;
               index_next = '0;
               if (in_valid) begin
                  capture = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               if (xfer) begin
                  index_next = index + IDX_W'(1);
               end
               if (in_valid) begin
                  overflow_set = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         index    <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state <= state_next;
         index <= index_next;
         done  <= done_next;
         if (overflow_set) begin
            overflow <= 1'b1;
         end
      end
   end

   // Buffer has no reset; it is fully overwritten on every accepted frame.
   always_ff @(posedge clk) begin
      if (capture && !rst) begin
         for (int f = 0; f < Felements; f++) begin
            for (int r = 0; r < Elements; r++) begin
               for (int c = 0; c < Elements; c++) begin
                  frame_buf[f*Elements*Elements + r*Elements + c] <= ImagesIn[f][r][c];
               end
            end
         end
      end
   end

   assign out_valid = (state == STREAM);
   assign busy      = (state == STREAM);
   assign out_index = index;
   assign out_last  = out_valid && at_last;
   assign out_data  = out_valid ? relu(frame_buf[index]) : 32'h0000_0000;

endmodule
